muldiv_unit: RTL
================

# muldiv_unit

Parametrised multiply/divide unit with HI/LO result registers for the EX stage of the five-stage pipeline, generalising the fixed 32-bit HI/LO unit. It accepts one operation per start pulse and computes the result at issue. It then holds `busy` for a configurable number of cycles before committing the result to HI/LO. It adds multiply-accumulate modes, independently configurable multiply and divide latencies, and defined divide-by-zero and overflow results.

## Interface
Parameters:
- `WIDTH`, 32: operand and HI/LO width.
- `MUL_CYCLES`, 5: busy cycles for mult/multu/madd/maddu/msub/msubu; legal range is 1 or more.
- `DIV_CYCLES`, 10: busy cycles for div/divu; legal range is 1 or more.

Ports:
- `clk` in 1: the single clock.
- `reset` in 1: synchronous, active-high.
- `start` in 1: issue strobe; sampled on the rising edge.
- `op` in 4: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 madd, 6 maddu, 7 msub, 8 msubu, 9 mthi, 10 mtlo; 11–15 are treated as none.
- `a` in WIDTH: rs operand, already forwarded.
- `b` in WIDTH: rt operand, already forwarded.
- `busy` out 1: registered; high while an operation is in flight.
- `hi` out WIDTH: HI register.
- `lo` out WIDTH: LO register.

## Operation
- A command is accepted on an edge with `start`=1, `busy`=0 and `op` in 1..10. All other start edges are ignored, and no state changes.
  - Start while busy is ignored. The stall unit must use `start | busy` to hold mf*/md instructions in D.
- mthi/mtlo write `hi` or `lo` with `a` on the accepting edge. They have zero latency and `busy` stays 0.
- On an accepted mul/div op:
  - The full result is computed from `a` and `b` at the accepting edge and stored in internal pending registers `p_hi`/`p_lo`.
  - The counter loads `MUL_CYCLES` or `DIV_CYCLES`.
- Arithmetic:
  - mult/multu: {hi,lo} = 2·WIDTH-bit product; signed or unsigned respectively.
  - madd(u): {hi,lo} = {hi,lo} + product.
  - msub(u): {hi,lo} = {hi,lo} − product.
  - For madd/maddu/msub/msubu, the accumulate uses the {hi,lo} value present at commit time. This equals the issue-time value, since no other write can occur while busy. Arithmetic is modulo 2^(2·WIDTH).
  - div/divu: lo = quotient, hi = remainder. Signed division truncates toward zero, and the remainder takes the sign of the dividend.
  - Divide by zero (b=0): lo = all ones, hi = a. This applies to both signed and unsigned divide.
  - Signed overflow (a = most negative value, b = −1): lo = a, hi = 0.
- States are IDLE (counter 0) and RUN (counter > 0).
  - IDLE → RUN on an accepted mul/div op.
  - In RUN the counter decrements each edge. The edge where the counter goes from 1 to 0 commits `p_hi`/`p_lo` into `hi`/`lo` and returns to IDLE.
- `reset` (including mid-operation) clears the counter, `busy`, `hi`, `lo`, `p_hi` and `p_lo` to 0. A pending operation is discarded.
- When `reset` and `start` are high on the same edge, `reset` wins.

## Timing
- Reset values: `busy`=0, `hi`=0, `lo`=0.
- Issue on edge T with latency N:
  - `busy` is 1 from after edge T through the cycle before edge T+N.
  - `hi`/`lo` take the new value after edge T+N, the same edge on which `busy` falls.
  - A new command is accepted at edge T+N+1 at the earliest; `busy` must be sampled 0.
- mthi/mtlo issued at edge T are visible on `hi`/`lo` after edge T.
- `hi`/`lo` never change except on a commit edge, an accepted mthi/mtlo edge, or reset.
- mfhi/mflo read `hi`/`lo` directly with no bypass. The stall unit guarantees that no read occurs while `start | busy` is high.

## Test plan
- Reset, then mult with a=0xFFFFFFFE, b=3 (signed), MUL_CYCLES=5 → `busy` is high for exactly 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- multu with a=0xFFFFFFFF, b=0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001.
- mthi 0, mtlo 10, then madd a=2, b=3, then msubu a=1, b=1:
  - after madd: hi=0, lo=16;
  - after msubu: lo=15.
  - Also mtlo 0 then msub a=1, b=1 → hi=lo=0xFFFFFFFF.
- div with a=−7 (0xFFFFFFF9), b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF after exactly DIV_CYCLES.
  - divu a=7, b=0 → lo=0xFFFFFFFF, hi=7.
  - div a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0.
- Start div, then assert start with mtlo a=5 at cycle 3 of busy → ignored; the final lo/hi are the division result, and lo≠5.
- Start mult, then assert reset at cycle 2 → next cycle `busy`=0 and hi=lo=0, and no late commit occurs. Repeat with `WIDTH`=16, `MUL_CYCLES`=1 → multu 0xFFFF×0xFFFF gives hi=0xFFFE, lo=0x0001 with a single busy cycle.

Source files
------------

// File: rtl/muldiv_unit.sv
// Multiply/divide unit with HI/LO registers: result computed at issue, held in
// pending registers, committed after a per-class busy latency.
module muldiv_unit #(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  typedef enum logic [3:0] {
    OP_NONE  = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MADD  = 4'd5,
    OP_MADDU = 4'd6,
    OP_MSUB  = 4'd7,
    OP_MSUBU = 4'd8,
    OP_MTHI  = 4'd9,
    OP_MTLO  = 4'd10
  } op_e;

  typedef enum logic {IDLE, RUN} state_e;

  state_e             state, state_n;
  logic [CW-1:0]      cnt, cnt_n;
  logic               busy_n;
  logic [WIDTH-1:0]   hi_n, lo_n, p_hi, p_lo, p_hi_n, p_lo_n;
  logic [2*WIDTH-1:0] acc, sprod, uprod, res;
  logic [WIDTH-1:0]   sq, sr, uq, ur, min_neg;
  logic               div_zero, div_ovf;

  // Full result at issue; accumulate uses current {hi,lo}, which cannot
  // change while busy, so this matches a commit-time accumulate.
  always_comb begin
    acc      = {hi, lo};
    sprod    = $signed({{WIDTH{a[WIDTH-1]}}, a}) * $signed({{WIDTH{b[WIDTH-1]}}, b});
    uprod    = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
    min_neg  = {1'b1, {(WIDTH-1){1'b0}}};
    div_zero = (b == '0);
    div_ovf  = (a == min_neg) && (b == '1);
    sq       = $signed(a) / $signed(b);
    sr       = $signed(a) % $signed(b);
    uq       = a / b;
    ur       = a % b;
    res      = '0;
    case (op)
      OP_MULT:  res = sprod;
      OP_MULTU: res = uprod;
      OP_MADD:  res = acc + sprod;
      OP_MADDU: res = acc + uprod;
      OP_MSUB:  res = acc - sprod;
      OP_MSUBU: res = acc - uprod;
      OP_DIV: begin
        if (div_zero)     res = {a, {WIDTH{1'b1}}};
        else if (div_ovf) res = {{WIDTH{1'b0}}, a};
        else              res = {sr, sq};
      end
      OP_DIVU: begin
        if (div_zero) res = {a, {WIDTH{1'b1}}};
        else          res = {ur, uq};
      end
      default: res = '0;
    endcase
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    busy_n  = busy;
    hi_n    = hi;
    lo_n    = lo;
    p_hi_n  = p_hi;
    p_lo_n  = p_lo;
    case (state)
      IDLE: begin
        if (start) begin
          case (op)
            OP_MTHI: hi_n = a;
            OP_MTLO: lo_n = a;
            OP_MULT, OP_MULTU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: begin
              {p_hi_n, p_lo_n} = res;
              cnt_n   = CW'(MUL_CYCLES);
              state_n = RUN;
              busy_n  = 1'b1;
            end
            OP_DIV, OP_DIVU: begin
              {p_hi_n, p_lo_n} = res;
              cnt_n   = CW'(DIV_CYCLES);
              state_n = RUN;
              busy_n  = 1'b1;
            end
            default: ;
          endcase
        end
      end
      RUN: begin
        cnt_n = cnt - CW'(1);
        if (cnt == CW'(1)) begin
          hi_n    = p_hi;
          lo_n    = p_lo;
          state_n = IDLE;
          busy_n  = 1'b0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      busy  <= 1'b0;
      hi    <= '0;
      lo    <= '0;
      p_hi  <= '0;
      p_lo  <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      busy  <= busy_n;
      hi    <= hi_n;
      lo    <= lo_n;
      p_hi  <= p_hi_n;
      p_lo  <= p_lo_n;
    end
  end

endmodule
